mips_mc_controller_ext: RTL and testbench

Parametrised multicycle MIPS control unit: Moore FSM plus ALU decoder driving the shared-memory multicycle datapath. Successor to the base lw/sw/R/beq controller; adds bne, addi, andi/ori/slti, j, illegal-opcode detection, and on-chip PC-enable generation from the ALU zero flag. Sits between the instruction register (opcode/funct) and datapath mux/enable controls.

---
 rtl/mips_mc_controller_ext_if.sv | 41 ++++
 rtl/mips_mc_controller_ext.sv | 205 ++++++++++++++++++++
 tb/tb_mips_mc_controller_ext.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_controller_ext_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller side drives every mux select and write enable.
interface mips_mc_controller_ext_if #(
  parameter int ALUCTL_W = 3
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                zero;
  logic                iord;
  logic                memwrite;
  logic                irwrite;
  logic                regdst;
  logic                memtoreg;
  logic                regwrite;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic                extop;
  logic [ALUCTL_W-1:0] alucontrol;
  logic [1:0]          pcsrc;
  logic                pcwrite;
  logic                branch;
  logic                pcen;
  logic                illegal;
  logic [3:0]          state_o;

  modport master (
    input  opcode, funct, zero,
    output iord, memwrite, irwrite, regdst,
    output memtoreg, regwrite, alusrca, alusrcb,
    output extop, alucontrol, pcsrc, pcwrite,
    output branch, pcen, illegal, state_o
  );

  modport slave (
    output opcode, funct, zero,
    input  iord, memwrite, irwrite, regdst,
    input  memtoreg, regwrite, alusrca, alusrcb,
    input  extop, alucontrol, pcsrc, pcwrite,
    input  branch, pcen, illegal, state_o
  );
endinterface

// File: rtl/mips_mc_controller_ext.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder, with
// bne/addi/andi/ori/slti/j support and illegal-instruction detection.
module mips_mc_controller_ext #(
  parameter int ALUCTL_W     = 3,
  parameter int EN_BNE       = 1,
  parameter int EN_IMM_LOGIC = 1,
  parameter int EN_JUMP      = 1
) (
  input logic clk,
  input logic rst,
  mips_mc_controller_ext_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_SLT = 3'b111;

  state_t     state;
  state_t     st;
  logic       is_mem, is_r, is_br, is_imm;
  logic       is_jmp, is_bne, is_logic, op_ok;
  logic       r_ok, i_ext;
  logic [2:0] r_alu, i_alu, alu;

  always_comb begin
    is_bne   = bus.opcode == OP_BNE;
    is_logic = (bus.opcode == OP_ANDI) ||
               (bus.opcode == OP_ORI)  ||
               (bus.opcode == OP_SLTI);
    is_mem   = (bus.opcode == OP_LW) ||
               (bus.opcode == OP_SW);
    is_r     = bus.opcode == OP_R;
    is_br    = (bus.opcode == OP_BEQ) ||
               ((EN_BNE != 0) && is_bne);
    is_imm   = (bus.opcode == OP_ADDI) ||
               ((EN_IMM_LOGIC != 0) && is_logic);
    is_jmp   = (EN_JUMP != 0) && (bus.opcode == OP_J);
    op_ok    = is_mem | is_r | is_br | is_imm | is_jmp;
  end

  always_comb begin
    r_ok  = 1'b1;
    r_alu = A_ADD;
    case (bus.funct)
      6'b100000: r_alu = A_ADD;
      6'b100010: r_alu = A_SUB;
      6'b100100: r_alu = A_AND;
      6'b100101: r_alu = A_OR;
      6'b101010: r_alu = A_SLT;
      default:   r_ok  = 1'b0;
    endcase
  end

  // Logical immediates zero-extend; addi and slti sign-extend.
  always_comb begin
    i_alu = A_ADD;
    i_ext = 1'b0;
    unique case (1'b1)
      bus.opcode == OP_ANDI: begin
        i_alu = A_AND;
        i_ext = 1'b1;
      end
      bus.opcode == OP_ORI: begin
        i_alu = A_OR;
        i_ext = 1'b1;
      end
      bus.opcode == OP_SLTI: i_alu = A_SLT;
      default: i_alu = A_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            is_mem:  state <= S_MEMADR;
            is_r:    state <= S_EXECUTE;
            is_br:   state <= S_BRANCH;
            is_imm:  state <= S_IMMEX;
            is_jmp:  state <= S_JUMP;
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR:
          state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state <= S_MEMWB;
        S_EXECUTE: state <= r_ok ? S_ALUWB : S_FETCH;
        S_IMMEX:   state <= S_IMMWB;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // In reset the datapath sees FETCH selects with every write held off.
  always_comb begin
    st           = rst ? state : S_FETCH;
    alu          = A_ADD;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.extop    = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.illegal  = 1'b0;
    case (st)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = 1'b1;
        bus.pcwrite = 1'b1;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        bus.illegal = ~op_ok;
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: bus.iord = 1'b1;
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        alu         = r_alu;
        bus.illegal = ~r_ok;
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        alu         = A_SUB;
        bus.pcsrc   = 2'b01;
        bus.branch  = 1'b1;
      end
      S_IMMEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        alu         = i_alu;
        bus.extop   = i_ext;
      end
      S_IMMWB: bus.regwrite = 1'b1;
      S_JUMP: begin
        bus.pcsrc   = 2'b10;
        bus.pcwrite = 1'b1;
      end
      default: alu = A_ADD;
    endcase
    if (!rst) begin
      bus.irwrite = 1'b0;
      bus.pcwrite = 1'b0;
    end
  end

  assign bus.pcen = bus.pcwrite |
                    (bus.branch & (bus.zero ^ is_bne));
  assign bus.alucontrol = ALUCTL_W'(alu);
  assign bus.state_o    = state;

endmodule

// File: tb/tb_mips_mc_controller_ext.sv
// Bench: two controllers (all features on / all optional decodes off)
// checked every cycle against an instruction-level sequence model.
module tb_mips_mc_controller_ext;

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst;
    logic       memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [3:0] aluc;
    logic [1:0] pcsrc;
    logic       pcwrite, branch, pcen, illegal;
    logic [3:0] st;
  } obs_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_RBAD = 3;
  localparam int C_BR = 4, C_IMM = 5, C_J = 6, C_ILL = 7;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010, JMP = 6'b000010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_mc_controller_ext_if #(.ALUCTL_W(3)) ia ();
  mips_mc_controller_ext_if #(.ALUCTL_W(4)) ib ();

  mips_mc_controller_ext #(
    .ALUCTL_W(3), .EN_BNE(1), .EN_IMM_LOGIC(1), .EN_JUMP(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia.master));

  mips_mc_controller_ext #(
    .ALUCTL_W(4), .EN_BNE(0), .EN_IMM_LOGIC(0), .EN_JUMP(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cls[2];
  int idx[2];
  logic [5:0] opv[2], fnv[2], dop[2], dfn[2];
  bit have_dir[2];
  obs_t last_a, last_b;
  obs_t ha[8], hb[8];

  function automatic obs_t get_a();
    obs_t o;
    o = '{ia.iord, ia.memwrite, ia.irwrite, ia.regdst,
          ia.memtoreg, ia.regwrite, ia.alusrca, ia.alusrcb,
          ia.extop, {1'b0, ia.alucontrol}, ia.pcsrc,
          ia.pcwrite, ia.branch, ia.pcen, ia.illegal,
          ia.state_o};
    return o;
  endfunction

  function automatic obs_t get_b();
    obs_t o;
    o = '{ib.iord, ib.memwrite, ib.irwrite, ib.regdst,
          ib.memtoreg, ib.regwrite, ib.alusrca, ib.alusrcb,
          ib.extop, ib.alucontrol, ib.pcsrc,
          ib.pcwrite, ib.branch, ib.pcen, ib.illegal,
          ib.state_o};
    return o;
  endfunction

  function automatic logic [3:0] falu(logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'hf;
    endcase
  endfunction

  function automatic int classify(logic [5:0] op, logic [5:0] fn, bit en);
    if (op == LW) return C_LW;
    if (op == SW) return C_SW;
    if (op == RT) return (falu(fn) != 4'hf) ? C_R : C_RBAD;
    if (op == BEQ) return C_BR;
    if (op == BNE) return en ? C_BR : C_ILL;
    if (op == ADDI) return C_IMM;
    if (op == ANDI || op == ORI || op == SLTI)
      return en ? C_IMM : C_ILL;
    if (op == JMP) return en ? C_J : C_ILL;
    return C_ILL;
  endfunction

  // Instruction latency in cycles, FETCH included.
  function automatic int seq_len(int c);
    int lens[8] = '{5, 4, 4, 3, 3, 4, 3, 2};
    return lens[c];
  endfunction

  function automatic int seq_state(int c, int i);
    int tail[8][3] = '{'{2, 3, 4}, '{2, 5, 0}, '{6, 7, 0},
                       '{6, 0, 0}, '{8, 0, 0}, '{9, 10, 0},
                       '{11, 0, 0}, '{0, 0, 0}};
    if (i < 2) return i;
    return tail[c][i-2];
  endfunction

  function automatic obs_t model(int s, int c, logic [5:0] op,
                                 logic [5:0] fn, logic z, logic r);
    obs_t e;
    int ms;
    e = '0;
    e.aluc = 4'b0010;
    e.st = 4'(s);
    ms = r ? s : 0;
    case (ms)
      0: begin
        e.alusrcb = 2'b01; e.irwrite = 1; e.pcwrite = 1; e.pcen = 1;
      end
      1: begin e.alusrcb = 2'b11; e.illegal = (c == C_ILL); end
      2: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3: e.iord = 1;
      4: begin e.memtoreg = 1; e.regwrite = 1; end
      5: begin e.iord = 1; e.memwrite = 1; end
      6: begin
        e.alusrca = 1;
        if (c == C_R) e.aluc = falu(fn);
        else e.illegal = 1;
      end
      7: begin e.regdst = 1; e.regwrite = 1; end
      8: begin
        e.alusrca = 1; e.aluc = 4'b0110; e.pcsrc = 2'b01; e.branch = 1;
        e.pcen = (op == BNE) ? !z : z;
      end
      9: begin
        e.alusrca = 1; e.alusrcb = 2'b10;
        if (op == ANDI) begin e.aluc = 4'b0000; e.extop = 1; end
        if (op == ORI) begin e.aluc = 4'b0001; e.extop = 1; end
        if (op == SLTI) e.aluc = 4'b0111;
      end
      10: e.regwrite = 1;
      11: begin e.pcsrc = 2'b10; e.pcwrite = 1; e.pcen = 1; end
      default: e.aluc = 4'b0010;
    endcase
    if (!r) begin e.irwrite = 0; e.pcwrite = 0; e.pcen = 0; end
    return e;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic cmp(string n, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d got %h want %h", n, cyc, a, e);
    end
  endtask

  task automatic start(int d);
    logic [5:0] fl[5] = '{6'b100000, 6'b100010, 6'b100100,
                          6'b100101, 6'b101010};
    logic [5:0] op, fn;
    fn = 6'($urandom);
    case ($urandom_range(0, 12))
      0: op = LW;
      1: op = SW;
      2, 3: begin op = RT; fn = fl[$urandom_range(0, 4)]; end
      4: op = RT;
      5: op = BEQ;
      6: op = BNE;
      7: op = ADDI;
      8: op = ANDI;
      9: op = ORI;
      10: op = SLTI;
      11: op = JMP;
      default: op = 6'($urandom);
    endcase
    if (have_dir[d]) begin op = dop[d]; fn = dfn[d]; end
    have_dir[d] = 0;
    opv[d] = op;
    fnv[d] = fn;
    cls[d] = classify(op, fn, d == 0);
    idx[d] = 0;
  endtask

  task automatic cycle(input logic r, input logic z);
    obs_t ea, eb;
    for (int d = 0; d < 2; d++)
      if (idx[d] >= seq_len(cls[d])) start(d);
    ia.opcode = opv[0]; ia.funct = fnv[0]; ia.zero = z;
    ib.opcode = opv[1]; ib.funct = fnv[1]; ib.zero = z;
    rst = r;
    @(negedge clk);
    last_a = get_a();
    last_b = get_b();
    ea = model(seq_state(cls[0], idx[0]), cls[0], opv[0], fnv[0], z, r);
    eb = model(seq_state(cls[1], idx[1]), cls[1], opv[1], fnv[1], z, r);
    cmp("dut_a", last_a, ea);
    cmp("dut_b", last_b, eb);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) idx[d] = r ? idx[d] + 1 : 99;
    cyc++;
  endtask

  task automatic run_a(logic [5:0] op, logic [5:0] fn, logic z, int n);
    have_dir[0] = 1; dop[0] = op; dfn[0] = fn;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, z);
      ha[i] = last_a;
      hb[i] = last_b;
    end
  endtask

  initial begin
    idx[0] = 99; idx[1] = 99;
    cls[0] = C_ILL; cls[1] = C_ILL;
    have_dir[0] = 0; have_dir[1] = 0;
    rst = 1'b0;
    ia.opcode = '0; ia.funct = '0; ia.zero = 1'b0;
    ib.opcode = '0; ib.funct = '0; ib.zero = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0);
    chk("reset_state", 32'(last_a.st), 0);
    chk("reset_irwrite", 32'(last_a.irwrite), 0);

    run_a(LW, 6'd0, 1'b0, 5);
    chk("lw_states", {ha[0].st, ha[1].st, ha[2].st, ha[3].st, ha[4].st},
        32'h01234);
    chk("lw_wb", {ha[4].memtoreg, ha[4].regwrite, ha[3].regwrite}, 3'b110);
    chk("lw_irwrite", {ha[0].irwrite, ha[1].irwrite, ha[2].irwrite,
        ha[3].irwrite, ha[4].irwrite}, 5'b10000);

    run_a(RT, 6'b100000, 1'b0, 4);
    chk("add_alu", 32'(ha[2].aluc), 32'h2);
    chk("add_wb", {ha[3].st, ha[3].regdst, ha[3].regwrite}, 6'h1f);
    run_a(RT, 6'b100010, 1'b1, 4);
    chk("sub_alu", 32'(ha[2].aluc), 32'h6);

    run_a(BEQ, 6'd0, 1'b1, 3);
    chk("beq_z1", {ha[2].st, ha[2].pcsrc, ha[2].pcen}, 7'b1000_01_1);
    run_a(BNE, 6'd0, 1'b1, 3);
    chk("bne_z1", {ha[2].pcsrc, ha[2].pcen}, 3'b01_0);
    run_a(BNE, 6'd0, 1'b0, 3);
    chk("bne_z0", {ha[2].pcsrc, ha[2].pcen}, 3'b01_1);

    run_a(ANDI, 6'd0, 1'b0, 4);
    chk("andi_ex", {ha[2].aluc, ha[2].extop}, 5'b0000_1);
    run_a(SLTI, 6'd0, 1'b0, 4);
    chk("slti_ex", {ha[2].aluc, ha[2].extop}, 5'b0111_0);
    chk("imm_wb", {ha[3].st, ha[3].regdst, ha[3].regwrite}, 6'b1010_01);

    cycle(1'b0, 1'b0);
    have_dir[1] = 1; dop[1] = JMP; dfn[1] = 6'd0;
    run_a(JMP, 6'd0, 1'b0, 3);
    chk("j_a", {ha[1].st, ha[2].st, ha[2].pcsrc, ha[2].pcwrite},
        11'b0001_1011_10_1);
    chk("j_b_ill", {hb[1].st, hb[1].illegal, hb[1].pcwrite}, 6'b0001_10);
    chk("j_b_next", 32'(hb[2].st), 0);

    run_a(RT, 6'b000111, 1'b0, 3);
    chk("rbad_ill", {ha[2].st, ha[2].illegal}, 5'b0110_1);
    chk("rbad_nowb", {ha[0].regwrite, ha[1].regwrite, ha[2].regwrite}, 0);

    have_dir[0] = 1; dop[0] = SW; dfn[0] = 6'd0;
    cycle(1'b1, 1'b0);
    chk("rbad_next", 32'(last_a.st), 0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("rst_memwr", {last_a.st, last_a.memwrite, last_a.iord}, 6'b0101_00);
    cycle(1'b1, 1'b0);
    chk("rst_after", 32'(last_a.st), 0);

    repeat (2000) cycle($urandom_range(0, 39) != 0, 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
